// File: rtl/uart_periph_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_periph_pkg
// Brief    : Shared register map, CON bit positions and TX FSM encoding.
// Revision : 1.0
// ============================================================================
package uart_periph_pkg;

  localparam logic [31:0] C_ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] C_ADDR_RXD = 32'h4000_001C;
  localparam logic [31:0] C_ADDR_CON = 32'h4000_0020;

  localparam int C_CON_RX_READY  = 0;
  localparam int C_CON_TX_FULL   = 1;
  localparam int C_CON_TX_IDLE   = 2;
  localparam int C_CON_OVERRUN   = 3;
  localparam int C_CON_RX_IRQ_EN = 4;
  localparam int C_CON_TX_IRQ_EN = 5;

  localparam logic [1:0] TX_IDLE      = 2'd0;
  localparam logic [1:0] TX_LAUNCH    = 2'd1;
  localparam logic [1:0] TX_WAIT_BUSY = 2'd2;
  localparam logic [1:0] TX_WAIT_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Byte-wide synchronous FIFO; a push into a full FIFO is accepted
//            only when a pop happens in the same cycle, otherwise dropped.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [7:0]                 i_din,
  input  logic                       i_pop,
  output logic [7:0]                 o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          w_pop_ok;
  logic          w_push_ok;

  assign o_empty   = (count_q == '0);
  assign o_full    = (count_q == C_DEPTH);
  assign o_count   = count_q;
  assign o_dout    = mem_q[rd_ptr_q];
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push_ok) begin
      mem_d[wr_ptr_q] = i_din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (w_pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_push_ok, w_pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/uart_periph_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_periph_ctrl
// Brief    : Memory-mapped UART controller: TX byte FIFO sequenced into
//            uart_tx, RX holding register with overrun flag, level IRQ.
// Revision : 1.0
// ============================================================================
module uart_periph_ctrl
  import uart_periph_pkg::*;
#(
  parameter int          TX_DEPTH = 4,
  parameter logic [31:0] ADDR_TXD = C_ADDR_TXD,
  parameter logic [31:0] ADDR_RXD = C_ADDR_RXD,
  parameter logic [31:0] ADDR_CON = C_ADDR_CON
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [1:0]    state_q, state_d;
  logic          rx_ready_q, rx_ready_d;
  logic [7:0]    rx_buf_q, rx_buf_d;
  logic          overrun_q, overrun_d;
  logic          rx_irq_en_q, rx_irq_en_d;
  logic          tx_irq_en_q, tx_irq_en_d;
  logic          irq_q, irq_d;

  logic          w_wr_txd;
  logic          w_wr_con;
  logic          w_rd_rxd;
  logic          w_pop;
  logic          w_overrun_evt;
  logic          w_tx_idle;
  logic [7:0]    w_fifo_head;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  logic          w_unused;

  assign w_wr_txd = wr_en & (addr == ADDR_TXD);
  assign w_wr_con = wr_en & (addr == ADDR_CON);
  assign w_rd_rxd = rd_en & (addr == ADDR_RXD);
  assign w_unused = &{1'b0, wdata[31:8]};

  uart_tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .i_clk   (sysclk),
    .i_rst   (reset),
    .i_push  (w_wr_txd),
    .i_din   (wdata[7:0]),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_tx_idle = (w_fifo_count == '0) & (state_q == TX_IDLE) & ~tx_busy;
  assign tx_start  = (state_q == TX_LAUNCH);
  assign tx_data   = tx_start ? w_fifo_head : 8'h00;

  // The head byte is popped in the same cycle it is presented with tx_start.
  always_comb begin
    state_d = state_q;
    w_pop   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!w_fifo_empty && !tx_busy) state_d = TX_LAUNCH;
      end
      TX_LAUNCH: begin
        w_pop   = 1'b1;
        state_d = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: begin
        if (tx_busy) state_d = TX_WAIT_DONE;
      end
      TX_WAIT_DONE: begin
        if (!tx_busy) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // A read in the same cycle as a new byte consumes the old one, so no overrun.
  assign w_overrun_evt = rx_valid & rx_ready_q & ~w_rd_rxd;

  always_comb begin
    rx_ready_d  = rx_ready_q;
    rx_buf_d    = rx_buf_q;
    overrun_d   = overrun_q;
    rx_irq_en_d = rx_irq_en_q;
    tx_irq_en_d = tx_irq_en_q;
    if (rx_valid) begin
      rx_ready_d = 1'b1;
      rx_buf_d   = rx_data;
    end else if (w_rd_rxd) begin
      rx_ready_d = 1'b0;
    end
    if (w_wr_con) begin
      rx_irq_en_d = wdata[C_CON_RX_IRQ_EN];
      tx_irq_en_d = wdata[C_CON_TX_IRQ_EN];
      if (wdata[C_CON_OVERRUN]) overrun_d = 1'b0;
    end
    if (w_overrun_evt) overrun_d = 1'b1;
    irq_d = (rx_irq_en_q & rx_ready_q) | (tx_irq_en_q & w_tx_idle);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= TX_IDLE;
      rx_ready_q  <= 1'b0;
      rx_buf_q    <= 8'h00;
      overrun_q   <= 1'b0;
      rx_irq_en_q <= 1'b0;
      tx_irq_en_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= rx_ready_d;
      rx_buf_q    <= rx_buf_d;
      overrun_q   <= overrun_d;
      rx_irq_en_q <= rx_irq_en_d;
      tx_irq_en_q <= tx_irq_en_d;
      irq_q       <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    rdata = 32'h0;
    if (rd_en) begin
      if (addr == ADDR_RXD) begin
        rdata = {24'h0, rx_buf_q};
      end else if (addr == ADDR_CON) begin
        rdata[C_CON_RX_READY]  = rx_ready_q;
        rdata[C_CON_TX_FULL]   = w_fifo_full;
        rdata[C_CON_TX_IDLE]   = w_tx_idle;
        rdata[C_CON_OVERRUN]   = overrun_q;
        rdata[C_CON_RX_IRQ_EN] = rx_irq_en_q;
        rdata[C_CON_TX_IRQ_EN] = tx_irq_en_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_periph_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_periph_ctrl
// Brief    : Directed self-checking bench for uart_periph_ctrl.
// Revision : 1.0
// ============================================================================
module tb_uart_periph_ctrl;

  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic        sysclk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        rx_valid;
  logic [7:0]  rx_data;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          start_cnt = 0;
  int          busy_cnt = 0;
  logic        busy_force = 1'b0;
  int          start_cyc [16];
  logic [7:0]  start_byte [16];
  int          wcyc;
  logic [31:0] rv;

  always #5 sysclk = ~sysclk;

  uart_periph_ctrl dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .addr     (addr),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .wdata    (wdata),
    .rdata    (rdata),
    .irq      (irq),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

  // uart_tx stand-in: busy for 100 cycles starting the cycle after tx_start.
  assign tx_busy = busy_force | (busy_cnt != 0);

  always @(posedge sysclk) begin
    cyc <= cyc + 1;
    if (tx_start === 1'b1) begin
      if (start_cnt < 16) begin
        start_cyc[start_cnt]  <= cyc;
        start_byte[start_cnt] <= tx_data;
      end
      start_cnt <= start_cnt + 1;
      busy_cnt  <= 100;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    rd_en = 1'b1;
    addr  = a;
    #1 d  = rdata;
    @(negedge sysclk);
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge sysclk);
    wr_en = 1'b0;
  endtask

  task automatic rxv(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge sysclk);
    rx_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr = 32'h0; rd_en = 1'b0; wr_en = 1'b0; wdata = 32'h0;
    rx_valid = 1'b0; rx_data = 8'h0;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;

    // Reset state
    check("rst_irq", {31'h0, irq}, 32'h0);
    addr = A_CON;
    #1 check("rst_rdata_no_rd", rdata, 32'h0);
    rd(A_CON, rv); check("rst_con", rv, 32'h4);
    rd(A_TXD, rv); check("txd_reads_0", rv, 32'h0);
    rd(32'h4000_0024, rv); check("unmapped_0", rv, 32'h0);
    check("rst_no_start", start_cnt, 0);

    // Single RX byte then read
    rxv(8'hb9);
    rd(A_CON, rv); check("rx_con_ready", rv, 32'h5);
    rd(A_RXD, rv); check("rx_b9", rv, 32'h0000_00b9);
    rd(A_CON, rv); check("rx_con_cleared", rv, 32'h4);

    // Overrun then W1C
    rxv(8'h96);
    rxv(8'h1e);
    rd(A_CON, rv); check("ovr_con", rv, 32'hD);
    rd(A_RXD, rv); check("ovr_rxd", rv, 32'h1e);
    rd(A_CON, rv); check("ovr_after_rd", rv, 32'hC);
    wr(A_CON, 32'h8);
    rd(A_CON, rv); check("ovr_w1c", rv, 32'h4);

    // Read coincident with a new byte: old byte returned, no overrun
    rxv(8'h11);
    rx_valid = 1'b1; rx_data = 8'h22; rd_en = 1'b1; addr = A_RXD;
    #1 check("coinc_old_byte", rdata, 32'h11);
    @(negedge sysclk);
    rx_valid = 1'b0; rd_en = 1'b0;
    rd(A_CON, rv); check("coinc_con", rv, 32'h5);
    rd(A_RXD, rv); check("coinc_new_byte", rv, 32'h22);

    // Overrun set wins over simultaneous W1C
    rxv(8'h33);
    rx_valid = 1'b1; rx_data = 8'h44; wr_en = 1'b1; addr = A_CON; wdata = 32'h8;
    @(negedge sysclk);
    rx_valid = 1'b0; wr_en = 1'b0;
    rd(A_CON, rv); check("set_wins_con", rv, 32'hD);
    wr(A_CON, 32'h8);
    rd(A_RXD, rv); check("set_wins_rxd", rv, 32'h44);
    rd(A_CON, rv); check("set_wins_clr", rv, 32'h4);

    // Two back-to-back TX bytes
    wcyc = cyc;
    wr(A_TXD, 32'h46);
    wr(A_TXD, 32'h69);
    for (int i = 0; i < 20 && start_cnt < 1; i++) @(negedge sysclk);
    check("tx1_seen", start_cnt, 1);
    check("tx1_latency", 32'(start_cyc[0] - wcyc), 32'd2);
    check("tx1_byte", {24'h0, start_byte[0]}, 32'h46);
    for (int i = 0; i < 400 && start_cnt < 2; i++) @(negedge sysclk);
    check("tx2_seen", start_cnt, 2);
    check("tx2_gap", 32'(start_cyc[1] - start_cyc[0]), 32'd103);
    check("tx2_byte", {24'h0, start_byte[1]}, 32'h69);
    repeat (200) @(negedge sysclk);
    check("tx_pulses_2", start_cnt, 2);
    rd(A_CON, rv); check("tx_done_idle", rv, 32'h4);

    // FIFO fill while busy; fifth byte dropped
    busy_force = 1'b1;
    for (int b = 1; b <= 4; b++) wr(A_TXD, 32'(b));
    rd(A_CON, rv); check("fifo_full", rv, 32'h2);
    wr(A_TXD, 32'h5);
    rd(A_CON, rv); check("fifo_full_drop", rv, 32'h2);
    check("fifo_no_start", start_cnt, 2);
    busy_force = 1'b0;
    for (int i = 0; i < 1000 && start_cnt < 6; i++) @(negedge sysclk);
    repeat (200) @(negedge sysclk);
    check("fifo_pulses", start_cnt, 6);
    for (int k = 0; k < 4; k++) check("fifo_order", {24'h0, start_byte[2+k]}, 32'(k + 1));
    rd(A_CON, rv); check("fifo_drained", rv, 32'h4);

    // IRQ enable, RX interaction, disable
    wr(A_CON, 32'h30);
    check("irq_delay", {31'h0, irq}, 32'h0);
    @(negedge sysclk);
    check("irq_on", {31'h0, irq}, 32'h1);
    rxv(8'h5a);
    check("irq_rx_hold", {31'h0, irq}, 32'h1);
    @(negedge sysclk);
    check("irq_rx_hold2", {31'h0, irq}, 32'h1);
    wr(A_CON, 32'h0);
    check("irq_off_delay", {31'h0, irq}, 32'h1);
    @(negedge sysclk);
    check("irq_off", {31'h0, irq}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
